// File: rtl/proj_fm_reader_if.sv
// Bundle of the reader's command, RAM read-port and output stream signals.
// The slave modport is the reader engine; the master modport is its environment.
interface proj_fm_reader_if #(
  parameter int ENTRIES   = 32,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = $clog2(ENTRIES)
);
  logic                 in_start;
  logic [ADDR_BITS-1:0] in_base_addr;
  logic [ADDR_BITS:0]   in_len;
  logic [ADDR_BITS-1:0] out_ram_addr;
  logic                 out_ram_re;
  logic [DATA_BITS-1:0] in_ram_rdata;
  logic [DATA_BITS-1:0] out_data;
  logic                 out_valid;
  logic                 in_ready;
  logic                 out_last;
  logic                 out_busy;
  logic                 out_done;

  modport slave (
    input  in_start, in_base_addr, in_len, in_ram_rdata, in_ready,
    output out_ram_addr, out_ram_re, out_data, out_valid, out_last, out_busy, out_done
  );

  modport master (
    output in_start, in_base_addr, in_len, in_ram_rdata, in_ready,
    input  out_ram_addr, out_ram_re, out_data, out_valid, out_last, out_busy, out_done
  );
endinterface

// File: rtl/proj_fm_reader.sv
// Read-out engine for the projection feature-map RAM: walks a wrapping address
// window, absorbs the one-cycle RAM latency through a 2-entry buffer and
// presents the words as a valid/ready stream with a last marker and done pulse.
module proj_fm_reader #(
  parameter int ENTRIES   = 32,
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = $clog2(ENTRIES)
) (
  input  logic             in_clk,
  input  logic             in_rst,
  proj_fm_reader_if.slave  bus
);

  localparam logic [ADDR_BITS:0]   LEN_MAX  = (ADDR_BITS+1)'(ENTRIES);
  localparam logic [ADDR_BITS:0]   CNT_ONE  = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_TOP = ADDR_BITS'(ENTRIES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [ADDR_BITS-1:0] addr_reg;
  logic [ADDR_BITS:0]   len_reg;
  logic [ADDR_BITS:0]   issue_cnt_reg;
  logic [ADDR_BITS:0]   remain_reg;

  // A read issued last cycle whose data is on in_ram_rdata now, plus its last tag
  logic inflight_reg;
  logic inflight_last_reg;

  // 2-entry output buffer; the last tag travels alongside each word
  logic [DATA_BITS-1:0] fifo_data_reg [2];
  logic                 fifo_last_reg [2];
  logic                 rd_ptr_reg;
  logic                 wr_ptr_reg;
  logic [1:0]           count_reg;

  logic [ADDR_BITS:0] len_clamped;
  logic               pop;
  logic [2:0]         occ;
  logic               issue;
  logic               issue_last;
  logic               drained;
  logic               busy;
  logic               done;

  // Credit, handshake and drain conditions shared by the FSM and datapath
  always_comb begin
    len_clamped = (bus.in_len > LEN_MAX) ? LEN_MAX : bus.in_len;
    pop         = (count_reg != 2'd0) && bus.in_ready;
    occ         = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    issue       = (state_reg == ST_READ) && (remain_reg != '0) && (occ < 3'd2);
    issue_last  = (issue_cnt_reg == (len_reg - CNT_ONE));
    drained     = !inflight_reg &&
                  ((count_reg == 2'd0) || ((count_reg == 2'd1) && pop));
  end

  // State register
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and status outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.in_start) begin
          state_next = (len_clamped == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        if (issue && (remain_reg == CNT_ONE)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (drained) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Window capture, address walk and issue/remaining counters
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      addr_reg          <= '0;
      len_reg           <= '0;
      issue_cnt_reg     <= '0;
      remain_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      if ((state_reg == ST_IDLE) && bus.in_start) begin
        addr_reg      <= bus.in_base_addr;
        len_reg       <= len_clamped;
        issue_cnt_reg <= '0;
        remain_reg    <= len_clamped;
      end else if (issue) begin
        addr_reg      <= (addr_reg == ADDR_TOP) ? '0 : addr_reg + ADDR_BITS'(1);
        issue_cnt_reg <= issue_cnt_reg + CNT_ONE;
        remain_reg    <= remain_reg - CNT_ONE;
      end
      inflight_reg      <= issue;
      inflight_last_reg <= issue && issue_last;
    end
  end

  // Output buffer: capture returning RAM data, advance head on handshake
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data_reg[i] <= '0;
        fifo_last_reg[i] <= 1'b0;
      end
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (inflight_reg) begin
        fifo_data_reg[wr_ptr_reg] <= bus.in_ram_rdata;
        fifo_last_reg[wr_ptr_reg] <= inflight_last_reg;
        wr_ptr_reg                <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end
  end

  // Stream and RAM-port outputs; data/last read as zero while the buffer is empty
  always_comb begin
    bus.out_ram_addr = addr_reg;
    bus.out_ram_re   = issue;
    bus.out_valid    = (count_reg != 2'd0);
    bus.out_data     = bus.out_valid ? fifo_data_reg[rd_ptr_reg] : '0;
    bus.out_last     = bus.out_valid ? fifo_last_reg[rd_ptr_reg] : 1'b0;
    bus.out_busy     = busy;
    bus.out_done     = done;
  end

endmodule
